neuron_phase_ctrl: RTL and testbench

NEURON_PHASE_CTRL -- requirements
Module: neuron_phase_ctrl

---
 rtl/neuron_phase_ctrl.sv | 153 +++++++++++++++
 tb/tb_neuron_phase_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : neuron_phase_ctrl
// Brief   : Sequences a neuron through forward / backward phases with fixed
//           cycle budgets, capturing the activation and the incoming gradient.
// Rev     : 1.0
// ============================================================================
module neuron_phase_ctrl #(
  parameter int BITS    = 16,
  parameter int FWD_CYC = 6,
  parameter int BWD_CYC = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            train,
  output logic            ready,
  output logic            FP,
  output logic            BP,
  input  logic [BITS-1:0] nrn_y,
  output logic [BITS-1:0] y_out,
  output logic            y_valid,
  input  logic            dz_valid,
  input  logic [BITS-1:0] dz_in,
  output logic            dz_ready,
  output logic [BITS-1:0] dz_out,
  output logic            done
);

  localparam logic [4:0] FWD_LAST = 5'(FWD_CYC - 1);
  localparam logic [4:0] BWD_LAST = 5'(BWD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FWD   = 3'd1,
    S_BWAIT = 3'd2,
    S_BSET  = 3'd3,
    S_BWD   = 3'd4
  } state_t;

  state_t          state_q,    state_d;
  logic [4:0]      cnt_q,      cnt_d;
  logic            train_q,    train_d;
  logic [BITS-1:0] y_out_q,    y_out_d;
  logic [BITS-1:0] dz_out_q,   dz_out_d;
  logic            fp_q,       fp_d;
  logic            bp_q,       bp_d;
  logic            ready_q,    ready_d;
  logic            y_valid_q,  y_valid_d;
  logic            done_q,     done_d;
  logic            dz_ready_q, dz_ready_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    train_d   = train_q;
    y_out_d   = y_out_q;
    dz_out_d  = dz_out_q;
    y_valid_d = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FWD;
          train_d = train;
          cnt_d   = 5'd0;
        end
      end
      S_FWD: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == FWD_LAST) begin
          y_out_d   = nrn_y;
          y_valid_d = 1'b1;
          if (train_q) begin
            state_d = S_BWAIT;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_BWAIT: begin
        // dz_ready_q is high exactly while parked here, so this is the handshake
        if (dz_valid && dz_ready_q) begin
          dz_out_d = dz_in;
          state_d  = S_BSET;
        end
      end
      S_BSET: begin
        cnt_d   = 5'd0;
        state_d = S_BWD;
      end
      S_BWD: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == BWD_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
    endcase

    // Phase code and handshakes are precomputed from the next state so they
    // leave the block straight from flops, aligned with the state register.
    fp_d       = (state_d == S_FWD) || (state_d == S_BWAIT) || (state_d == S_BSET);
    bp_d       = (state_d == S_BWAIT) || (state_d == S_BSET) || (state_d == S_BWD);
    ready_d    = (state_d == S_IDLE);
    dz_ready_d = (state_d == S_BWAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      train_q    <= 1'b0;
      y_out_q    <= '0;
      dz_out_q   <= '0;
      fp_q       <= 1'b0;
      bp_q       <= 1'b0;
      ready_q    <= 1'b1;
      y_valid_q  <= 1'b0;
      done_q     <= 1'b0;
      dz_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      train_q    <= train_d;
      y_out_q    <= y_out_d;
      dz_out_q   <= dz_out_d;
      fp_q       <= fp_d;
      bp_q       <= bp_d;
      ready_q    <= ready_d;
      y_valid_q  <= y_valid_d;
      done_q     <= done_d;
      dz_ready_q <= dz_ready_d;
    end
  end

  assign ready    = ready_q;
  assign FP       = fp_q;
  assign BP       = bp_q;
  assign y_out    = y_out_q;
  assign y_valid  = y_valid_q;
  assign dz_ready = dz_ready_q;
  assign dz_out   = dz_out_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_neuron_phase_ctrl
// Brief   : Directed scoreboard bench for neuron_phase_ctrl.
// Rev     : 1.0
// ============================================================================
module tb_neuron_phase_ctrl;

  localparam int K_PHASE = 0;
  localparam int K_READY = 1;
  localparam int K_YOUT  = 2;
  localparam int K_DZOUT = 3;
  localparam int K_DZR   = 4;
  localparam int K_YV    = 5;
  localparam int K_DONE  = 6;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        train;
  logic        ready;
  logic        fp;
  logic        bp;
  logic [15:0] nrn_y;
  logic [15:0] y_out;
  logic        y_valid;
  logic        dz_valid;
  logic [15:0] dz_in;
  logic        dz_ready;
  logic [15:0] dz_out;
  logic        done;

  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];

  neuron_phase_ctrl #(.BITS(16), .FWD_CYC(6), .BWD_CYC(9)) dut (
    .clk(clk), .rst(rst), .start(start), .train(train), .ready(ready),
    .FP(fp), .BP(bp), .nrn_y(nrn_y), .y_out(y_out), .y_valid(y_valid),
    .dz_valid(dz_valid), .dz_in(dz_in), .dz_ready(dz_ready),
    .dz_out(dz_out), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_PHASE: return "phase";
      K_READY: return "ready";
      K_YOUT:  return "y_out";
      K_DZOUT: return "dz_out";
      K_DZR:   return "dz_ready";
      K_YV:    return "y_valid";
      K_DONE:  return "done";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [15:0] kgot(input int k);
    case (k)
      K_PHASE: return {14'd0, fp, bp};
      K_READY: return {15'd0, ready};
      K_YOUT:  return y_out;
      K_DZOUT: return dz_out;
      K_DZR:   return {15'd0, dz_ready};
      K_YV:    return {15'd0, y_valid};
      K_DONE:  return {15'd0, done};
      default: return 16'hxxxx;
    endcase
  endfunction

  // Sorted insert keeps the queue in cycle order whatever the push order.
  task automatic push(input int c, input int k, input logic [15:0] v);
    exp_t e;
    int   i;
    e.cyc = c; e.kind = k; e.val = v;
    i = q.size();
    while (i > 0 && q[i-1].cyc > c) i--;
    q.insert(i, e);
  endtask

  task automatic push_range(input int c0, input int c1, input int k, input logic [15:0] v);
    for (int c = c0; c <= c1; c++) push(c, k, v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout cyc=%0d pending=%0d required=0", cyc, q.size());
      q.delete();
    end
  endtask

  // Monitor: compares every expectation due this cycle and flags unannounced pulses.
  initial begin : monitor
    exp_t        e;
    logic [15:0] got;
    bit          saw_yv;
    bit          saw_done;
    forever begin
      @(negedge clk);
      saw_yv   = 1'b0;
      saw_done = 1'b0;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          failures++;
          $display("FAIL %s_stale cyc=%0d due=%0d", kname(e.kind), cyc, e.cyc);
        end else begin
          got = kgot(e.kind);
          if (got !== e.val) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h required=%h", kname(e.kind), cyc, got, e.val);
          end
          if (e.kind == K_YV)   saw_yv   = 1'b1;
          if (e.kind == K_DONE) saw_done = 1'b1;
        end
      end
      if (y_valid === 1'b1 && !saw_yv) begin
        checks++;
        failures++;
        $display("FAIL unexpected_y_valid cyc=%0d got=1 required=0", cyc);
      end
      if (done === 1'b1 && !saw_done) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done cyc=%0d got=1 required=0", cyc);
      end
    end
  end

  initial begin : stim
    int e0;
    int f0;
    rst = 1'b1; start = 1'b0; train = 1'b0; nrn_y = 16'h0; dz_valid = 1'b0; dz_in = 16'h0;

    // Reset state
    for (int c = 1; c <= 3; c++) begin
      push(c, K_PHASE, 16'h0); push(c, K_READY, 16'h1); push(c, K_YOUT, 16'h0);
      push(c, K_DZOUT, 16'h0); push(c, K_DZR, 16'h0);
    end
    run_to(3);
    rst = 1'b0;
    tick();

    // Inference only, with dz_valid held high through FWD and IDLE
    e0 = cyc + 1;
    start = 1'b1; train = 1'b0; nrn_y = 16'h0340; dz_valid = 1'b1; dz_in = 16'h1234;
    push_range(e0, e0 + 5, K_PHASE, 16'h2);
    push(e0, K_READY, 16'h0);
    push(e0 + 2, K_DZR, 16'h0);
    push(e0 + 3, K_YOUT, 16'h0);
    push(e0 + 6, K_PHASE, 16'h0); push(e0 + 6, K_READY, 16'h1);
    push(e0 + 6, K_YV, 16'h1);    push(e0 + 6, K_DONE, 16'h1);
    push(e0 + 6, K_YOUT, 16'h0340); push(e0 + 6, K_DZOUT, 16'h0);
    push(e0 + 8, K_DZOUT, 16'h0);  push(e0 + 8, K_PHASE, 16'h0);
    tick();
    start = 1'b0;
    run_to(e0 + 8);
    dz_valid = 1'b0;
    drain();

    // Training pass, gradient arrives after five BWAIT cycles
    e0 = cyc + 1;
    start = 1'b1; train = 1'b1; nrn_y = 16'h1111; dz_in = 16'hFF80;
    push_range(e0, e0 + 5, K_PHASE, 16'h2);
    push(e0 + 6, K_YV, 16'h1); push(e0 + 6, K_YOUT, 16'h1111); push(e0 + 6, K_READY, 16'h0);
    push_range(e0 + 6, e0 + 11, K_PHASE, 16'h3);
    push_range(e0 + 6, e0 + 10, K_DZR, 16'h1);
    push(e0 + 10, K_DZOUT, 16'h0);
    push(e0 + 11, K_DZR, 16'h0); push(e0 + 11, K_DZOUT, 16'hFF80);
    push_range(e0 + 12, e0 + 20, K_PHASE, 16'h1);
    push(e0 + 16, K_READY, 16'h0);
    push(e0 + 21, K_PHASE, 16'h0); push(e0 + 21, K_DONE, 16'h1);
    push(e0 + 21, K_READY, 16'h1); push(e0 + 21, K_DZOUT, 16'hFF80);
    push(e0 + 21, K_YOUT, 16'h1111);
    tick();
    start = 1'b0;
    run_to(e0 + 10);
    dz_valid = 1'b1;
    tick();
    dz_valid = 1'b0;
    run_to(e0 + 23);
    drain();

    // Start held continuously across two inference passes
    e0 = cyc + 1;
    start = 1'b1; train = 1'b0; nrn_y = 16'h00A5;
    push_range(e0, e0 + 5, K_PHASE, 16'h2);
    push(e0 + 3, K_READY, 16'h0);
    push(e0 + 6, K_PHASE, 16'h0); push(e0 + 6, K_READY, 16'h1);
    push(e0 + 6, K_YV, 16'h1);    push(e0 + 6, K_DONE, 16'h1);
    push(e0 + 6, K_YOUT, 16'h00A5);
    push_range(e0 + 7, e0 + 12, K_PHASE, 16'h2);
    push(e0 + 7, K_READY, 16'h0);
    push(e0 + 10, K_YOUT, 16'h00A5);
    push(e0 + 13, K_PHASE, 16'h0); push(e0 + 13, K_YV, 16'h1);
    push(e0 + 13, K_DONE, 16'h1);  push(e0 + 13, K_YOUT, 16'h5A5A);
    run_to(e0 + 7);
    start = 1'b0; nrn_y = 16'h5A5A;
    run_to(e0 + 15);
    drain();

    // Reset while in BWD with cnt=4, then a normal pass
    e0 = cyc + 1;
    start = 1'b1; train = 1'b1; nrn_y = 16'h0042; dz_in = 16'h2222;
    push(e0 + 6, K_YV, 16'h1); push(e0 + 6, K_YOUT, 16'h0042);
    push_range(e0 + 6, e0 + 7, K_PHASE, 16'h3);
    push(e0 + 7, K_DZOUT, 16'h2222);
    push_range(e0 + 8, e0 + 12, K_PHASE, 16'h1);
    push(e0 + 13, K_PHASE, 16'h0); push(e0 + 13, K_READY, 16'h1);
    push(e0 + 13, K_YOUT, 16'h0);  push(e0 + 13, K_DZOUT, 16'h0);
    push(e0 + 13, K_DZR, 16'h0);
    tick();
    start = 1'b0;
    run_to(e0 + 6);
    dz_valid = 1'b1;
    tick();
    dz_valid = 1'b0;
    run_to(e0 + 12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    f0 = cyc + 1;
    start = 1'b1; train = 1'b0; nrn_y = 16'h0777;
    push_range(f0, f0 + 5, K_PHASE, 16'h2);
    push(f0 + 6, K_PHASE, 16'h0); push(f0 + 6, K_YV, 16'h1);
    push(f0 + 6, K_DONE, 16'h1);  push(f0 + 6, K_YOUT, 16'h0777);
    tick();
    start = 1'b0;
    run_to(f0 + 8);
    drain();

    // dz_valid and rst together in BWAIT: reset wins
    e0 = cyc + 1;
    start = 1'b1; train = 1'b1; nrn_y = 16'h0999; dz_in = 16'h3333;
    push(e0 + 6, K_YV, 16'h1); push(e0 + 6, K_YOUT, 16'h0999);
    push_range(e0 + 6, e0 + 8, K_PHASE, 16'h3);
    push(e0 + 8, K_DZR, 16'h1);
    push(e0 + 9, K_PHASE, 16'h0); push(e0 + 9, K_DZOUT, 16'h0);
    push(e0 + 9, K_READY, 16'h1); push(e0 + 9, K_DZR, 16'h0);
    push(e0 + 9, K_YOUT, 16'h0);
    push(e0 + 11, K_PHASE, 16'h0);
    tick();
    start = 1'b0;
    run_to(e0 + 8);
    dz_valid = 1'b1; rst = 1'b1;
    tick();
    dz_valid = 1'b0; rst = 1'b0;
    run_to(e0 + 12);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
